// File: rtl/fb_writer.sv
// Pixel write front-end for the 64x64 LED panel framebuffer.
// Single-pixel requests arrive over valid/ready and are queued in a small FIFO.
// A registered output stage drains the FIFO onto the framebuffer write port.
// A full-screen clear sweeps every address with one latched colour, but only
// after all pixels accepted before it have been written.
module fb_writer #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int COLOR_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_x,
    input  logic [5:0]         in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               fb_we,
    output logic [11:0]        fb_waddr,
    output logic [COLOR_W-1:0] fb_din,
    output logic               busy,
    output logic               clear_done,
    output logic               oob_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [6:0]       X_LIM         = 7'(WIDTH);
    localparam logic [6:0]       Y_LIM         = 7'(HEIGHT);
    localparam logic [11:0]      LAST_ADDR     = 12'hFFF;

    typedef struct packed {
        logic [5:0]         x;
        logic [5:0]         y;
        logic [COLOR_W-1:0] color;
    } pix_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    pix_t               fifo_mem [FIFO_DEPTH];
    pix_t               fifo_head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;

    logic               in_range;
    logic               accept;
    logic               push;
    logic               pop;
    logic               start_clear;
    logic               last_clear;

    logic               clear_pending;
    logic [COLOR_W-1:0] clr_color;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_head  = fifo_mem[rd_ptr];

    // in_ready is held low while reset is asserted, then follows FIFO space
    // and the clear sequencing so nothing slips in behind a pending clear.
    assign in_ready = rst && !fifo_full && !clear_pending && (state != CLEAR);

    // Out-of-range coordinates are accepted off the bus but never queued.
    assign in_range = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_range;

    assign busy = clear_pending || (state == CLEAR) || !fifo_empty || fb_we;

    // State register for the idle/clear sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus per-cycle decode: drain pixels first, start the sweep
    // only once the FIFO is empty, and leave the sweep after address 4095.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        start_clear = 1'b0;
        last_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end else if (clear_pending) begin
                    start_clear = 1'b1;
                    state_nxt   = CLEAR;
                end
            end
            CLEAR: begin
                if (fb_waddr == LAST_ADDR) begin
                    last_clear = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage holds only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{x: in_x, y: in_y, color: in_color};
        end
    end

    // Clear request flag: set once, cleared when the sweep begins; repeats
    // while a clear is pending or running are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_pending <= 1'b0;
        end else if (start_clear) begin
            clear_pending <= 1'b0;
        end else if (clear_req && !clear_pending && (state != CLEAR)) begin
            clear_pending <= 1'b1;
        end
    end

    // Fill colour is captured only by the request that actually arms a clear.
    always_ff @(posedge clk) begin
        if (clear_req && !clear_pending && (state != CLEAR) && !start_clear) begin
            clr_color <= clear_color;
        end
    end

    // Registered write port. During the sweep fb_waddr itself is the address
    // counter: it starts at 0 and steps once per cycle up to 4095.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_we      <= 1'b0;
            fb_waddr   <= '0;
            fb_din     <= '0;
            clear_done <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            clear_done <= 1'b0;
            oob_err    <= accept && !in_range;
            if (start_clear) begin
                fb_we    <= 1'b1;
                fb_waddr <= '0;
                fb_din   <= clr_color;
            end else if (state == CLEAR) begin
                if (last_clear) begin
                    clear_done <= 1'b1;
                end else begin
                    fb_we    <= 1'b1;
                    fb_waddr <= fb_waddr + 1'b1;
                    fb_din   <= clr_color;
                end
            end else if (pop) begin
                fb_we    <= 1'b1;
                fb_waddr <= {fifo_head.y, fifo_head.x};
                fb_din   <= fifo_head.color;
            end
        end
    end

endmodule
